// File: rtl/ctrl_pkg.sv
// Shared types and constants for the fetch / PC stage and the control FSM.
package ctrl_pkg;

    localparam int PC_W    = 12;
    localparam int INST_W  = 18;
    localparam int STACK_D = 8;
    localparam logic [PC_W-1:0] INT_VECTOR = 12'h001;

    // PC operation codes issued by the control FSM; codes 1000-1111 act as HOLD.
    typedef enum logic [3:0] {
        PC_HOLD   = 4'b0000,
        PC_INCR   = 4'b0001,
        PC_BRANCH = 4'b0010,
        PC_JUMP   = 4'b0011,
        PC_JSB    = 4'b0100,
        PC_RET    = 4'b0101,
        PC_INT    = 4'b0110,
        PC_RETI   = 4'b0111
    } pc_op_e;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUS  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_e;

    // Sign-extend an 8-bit branch displacement to PC width.
    function automatic logic [PC_W-1:0] sext_disp(input logic [7:0] d);
        return {{(PC_W-8){d[7]}}, d};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-bus handshake between the fetch stage (master) and memory (slave).
interface fetch_pc_unit_if;
    import ctrl_pkg::*;

    logic              cyc;
    logic              stb;
    logic [PC_W-1:0]   adr;
    logic [INST_W-1:0] dat;
    logic              ack;

    modport master (output cyc, stb, adr, input  dat, ack);
    modport slave  (input  cyc, stb, adr, output dat, ack);
endinterface

// File: rtl/fetch_pc_unit_return_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry; a pop when empty yields zero. Both conditions raise sticky flags.
module return_stack
    import ctrl_pkg::*;
#(
    parameter int DEPTH = STACK_D
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] pop_data_o,
    output logic            ovf_o,
    output logic            unf_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;      // next slot to write; top of stack is ptr_q-1
    logic [PTR_W:0]   count_q;
    logic             ovf_q;
    logic             unf_q;
    logic [PTR_W-1:0] top_idx;
    logic             empty;
    logic             full;

    assign top_idx    = ptr_q - PTR_W'(1);
    assign empty      = (count_q == '0);
    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_data_o = empty ? '0 : mem_q[top_idx];
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;

    // Storage entries: write the slot under the pointer on push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (push_i && (ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (push_i) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                count_q <= count_q + (PTR_W+1)'(1);
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_q <= 1'b1;
            end else begin
                ptr_q   <= top_idx;
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and program-counter stage: runs the instruction-bus
// handshake into the IR and applies PC operations from the control FSM.
module fetch_pc_unit
    import ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_req_i,
    input  logic [3:0]        pc_op_i,
    input  logic [7:0]        disp_i,
    input  logic [PC_W-1:0]   addr_i,
    fetch_pc_unit_if.master   bus,
    output logic [INST_W-1:0] ir_o,
    output logic              ir_valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              int_active_o,
    output logic              stack_ovf_o,
    output logic              stack_unf_o
);
    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   adr_q;
    logic [INST_W-1:0] ir_q;
    logic              adr_load;
    logic              ir_load;
    logic              bus_active;
    logic              ir_valid;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   int_pc_q, int_pc_d;
    logic              int_active_q, int_active_d;
    logic [PC_W-1:0]   pc_inc;
    logic              push;
    logic              pop;
    logic [PC_W-1:0]   pop_data;

    assign bus.cyc      = bus_active;
    assign bus.stb      = bus_active;
    assign bus.adr      = adr_q;
    assign ir_o         = ir_q;
    assign ir_valid_o   = ir_valid;
    assign pc_o         = pc_q;
    assign int_active_o = int_active_q;
    assign pc_inc       = pc_q + PC_W'(1);

    // Fetch FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state and outputs; ack only matters while in BUS.
    always_comb begin
        state_d    = state_q;
        bus_active = 1'b0;
        ir_valid   = 1'b0;
        adr_load   = 1'b0;
        ir_load    = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (fetch_req_i) begin
                    adr_load = 1'b1;
                    state_d  = FETCH_BUS;
                end
            end
            FETCH_BUS: begin
                bus_active = 1'b1;
                if (bus.ack) begin
                    ir_load = 1'b1;
                    state_d = FETCH_DONE;
                end
            end
            FETCH_DONE: begin
                ir_valid = 1'b1;
                state_d  = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Bus address is latched at fetch start so PC ops cannot disturb a cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q <= '0;
            ir_q  <= '0;
        end else begin
            if (adr_load) adr_q <= pc_q;
            if (ir_load)  ir_q  <= bus.dat;
        end
    end

    // PC operation decode.
    always_comb begin
        pc_d         = pc_q;
        int_pc_d     = int_pc_q;
        int_active_d = int_active_q;
        push         = 1'b0;
        pop          = 1'b0;
        case (pc_op_i)
            PC_INCR:   pc_d = pc_inc;
            PC_BRANCH: pc_d = pc_inc + sext_disp(disp_i);
            PC_JUMP:   pc_d = addr_i;
            PC_JSB: begin
                push = 1'b1;
                pc_d = addr_i;
            end
            PC_RET: begin
                pop  = 1'b1;
                pc_d = pop_data;
            end
            PC_INT: begin
                int_pc_d     = pc_q;
                pc_d         = INT_VECTOR;
                int_active_d = 1'b1;
            end
            PC_RETI: begin
                pc_d         = int_pc_q;
                int_active_d = 1'b0;
            end
            default: ;
        endcase
    end

    // PC and interrupt-return registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= '0;
            int_pc_q     <= '0;
            int_active_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            int_pc_q     <= int_pc_d;
            int_active_q <= int_active_d;
        end
    end

    return_stack #(.DEPTH(STACK_D)) u_stack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .pop_data_o  (pop_data),
        .ovf_o       (stack_ovf_o),
        .unf_o       (stack_unf_o)
    );

endmodule
